// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul result drain path.
package matmul_pkg;

  localparam int ACC_WIDTH = 16;
  localparam int SAT_CNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

endpackage

// File: rtl/matmul_result_drain_sat_shift.sv
// Arithmetic right shift followed by a signed clamp into the output width.
module sat_shift #(
  parameter int ACC_WIDTH = 16,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 0
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] res,
  output logic                        sat
);

  localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

  logic signed [ACC_WIDTH-1:0] shifted;

  always_comb begin
    shifted = acc >>> SHIFT;
    res     = shifted[OUT_WIDTH-1:0];
    sat     = 1'b0;
    if (shifted > MAX_V) begin
      res = MAX_V[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (shifted < MIN_V) begin
      res = MIN_V[OUT_WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/matmul_result_drain.sv
// Captures a packed result vector and streams it out one scaled, saturated
// element per handshake, counting how many elements clamped.
module matmul_result_drain #(
  parameter int N_ELEM    = 4,
  parameter int ACC_WIDTH = matmul_pkg::ACC_WIDTH,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = 0,
  parameter int IDX_W     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N_ELEM*ACC_WIDTH-1:0]        in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OUT_WIDTH-1:0]               out_data,
  output logic [IDX_W-1:0]                   out_idx,
  output logic                               out_last,
  input  logic                               sat_clear,
  output logic [matmul_pkg::SAT_CNT_W-1:0]   sat_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);
  localparam logic [matmul_pkg::SAT_CNT_W-1:0] SAT_MAX = '1;

  matmul_pkg::drain_state_t state;
  logic [N_ELEM-1:0][ACC_WIDTH-1:0] bank;
  logic elem_sat;
  logic capture;
  logic out_hs;

  assign out_hs   = out_valid && out_ready;
  assign out_last = (state == matmul_pkg::DRAIN) && (out_idx == LAST_IDX);
  // The final handshake frees the bank, so a new vector may land the same cycle.
  assign in_ready = (state == matmul_pkg::IDLE) || (out_hs && out_last);
  assign capture  = in_valid && in_ready;

  sat_shift #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT)
  ) u_sat_shift (
    .acc (bank[out_idx]),
    .res (out_data),
    .sat (elem_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= matmul_pkg::IDLE;
      out_valid <= 1'b0;
      out_idx   <= '0;
      bank      <= '0;
    end else if (capture) begin
      state     <= matmul_pkg::DRAIN;
      out_valid <= 1'b1;
      out_idx   <= '0;
      bank      <= in_data;
    end else if (out_hs) begin
      if (out_last) begin
        state     <= matmul_pkg::IDLE;
        out_valid <= 1'b0;
        out_idx   <= '0;
      end else begin
        out_idx <= out_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (sat_clear) begin
      sat_cnt <= '0;
    end else if (out_hs && elem_sat && (sat_cnt != SAT_MAX)) begin
      sat_cnt <= sat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_matmul_result_drain.sv
// Scoreboard bench: two drains (SHIFT=0 and SHIFT=2) share all inputs.
module tb_matmul_result_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;
  logic        sat_clear;

  logic        d0_in_ready, d0_out_valid, d0_out_last;
  logic [7:0]  d0_out_data;
  logic [1:0]  d0_out_idx;
  logic [15:0] d0_sat_cnt;
  logic        d2_in_ready, d2_out_valid, d2_out_last;
  logic [7:0]  d2_out_data;
  logic [1:0]  d2_out_idx;
  logic [15:0] d2_sat_cnt;

  int tests = 0;
  int fails = 0;
  int q0[$];
  int q2[$];
  int exp_idx = 0;

  always #5 clk = ~clk;

  matmul_result_drain #(.N_ELEM(4), .ACC_WIDTH(16), .OUT_WIDTH(8), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d0_in_ready), .in_data(in_data),
    .out_valid(d0_out_valid), .out_ready(out_ready), .out_data(d0_out_data),
    .out_idx(d0_out_idx), .out_last(d0_out_last), .sat_clear(sat_clear), .sat_cnt(d0_sat_cnt)
  );

  matmul_result_drain #(.N_ELEM(4), .ACC_WIDTH(16), .OUT_WIDTH(8), .SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .in_data(in_data),
    .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
    .out_idx(d2_out_idx), .out_last(d2_out_last), .sat_clear(sat_clear), .sat_cnt(d2_sat_cnt)
  );

  function automatic int sat_model(input int v, input int sh);
    int s;
    s = v >>> sh;
    if (s > 127) return 127;
    if (s < -128) return -128;
    return s;
  endfunction

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Scoreboard: pop/compare on each output handshake, push on each capture.
  always @(negedge clk) begin
    int e0, e2, a0, a2;
    logic signed [15:0] el;
    if (rst) begin
      q0.delete();
      q2.delete();
      exp_idx = 0;
    end else begin
      if (d0_out_valid && out_ready) begin
        tests++;
        if (q0.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: out idx %0d with empty scoreboard, required no output", d0_out_idx);
        end else begin
          e0 = q0.pop_front();
          e2 = q2.pop_front();
          a0 = int'($signed(d0_out_data));
          a2 = int'($signed(d2_out_data));
          if (a0 !== e0 || a2 !== e2 || int'(d0_out_idx) !== exp_idx ||
              d0_out_last !== (exp_idx == 3) || d2_out_valid !== 1'b1) begin
            fails++;
            $display("FAIL sb_elem: got s0=%0d s2=%0d idx=%0d last=%0b v2=%0b, required s0=%0d s2=%0d idx=%0d last=%0b v2=1",
                     a0, a2, d0_out_idx, d0_out_last, d2_out_valid, e0, e2, exp_idx, (exp_idx == 3));
          end
          exp_idx = (exp_idx == 3) ? 0 : exp_idx + 1;
        end
      end
      if (in_valid && d0_in_ready) begin
        for (int k = 0; k < 4; k++) begin
          el = in_data[k*16 +: 16];
          q0.push_back(sat_model(int'(el), 0));
          q2.push_back(sat_model(int'(el), 2));
        end
      end
    end
  end

  task automatic clear_sat();
    @(posedge clk); #1 sat_clear = 1'b1;
    @(posedge clk); #1 sat_clear = 1'b0;
  endtask

  task automatic send(input logic [63:0] v);
    int n = 0;
    in_data  = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!d0_in_ready && n < 50) begin @(negedge clk); n++; end
    tests++;
    if (!d0_in_ready) begin fails++; $display("FAIL send_timeout: in_ready=%0b, required 1", d0_in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    int n = 0;
    cyc = 0;
    while (n < 100) begin
      @(negedge clk); n++;
      if (!d0_out_valid) break;
      cyc++;
    end
    tests++;
    if (n >= 100) begin fails++; $display("FAIL drain_timeout: still valid after %0d cycles, required idle", n); end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sat_clear = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (d0_out_valid !== 1'b0 || d0_out_idx !== 2'd0 || d0_out_data !== 8'd0 ||
        d0_out_last !== 1'b0 || d0_sat_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_state: got v=%0b idx=%0d data=%0d last=%0b sat=%0d, required all 0",
               d0_out_valid, d0_out_idx, d0_out_data, d0_out_last, d0_sat_cnt);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (d0_in_ready !== 1'b1 || d0_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: got in_ready=%0b out_valid=%0b, required 1 0", d0_in_ready, d0_out_valid);
    end
  endtask

  task automatic test_basic();
    int cyc;
    clear_sat();
    out_ready = 1'b1;
    send(pk(10, -3, 127, 0));
    wait_idle(cyc);
    tests++;
    if (cyc !== 4 || d0_sat_cnt !== 16'd0) begin
      fails++;
      $display("FAIL basic: got cycles=%0d sat=%0d, required 4 0", cyc, d0_sat_cnt);
    end
  endtask

  task automatic test_saturate();
    int cyc;
    clear_sat();
    send(pk(300, -300, -128, 128));
    wait_idle(cyc);
    tests++;
    if (cyc !== 4 || d0_sat_cnt !== 16'd3 || d2_sat_cnt !== 16'd0) begin
      fails++;
      $display("FAIL saturate: got cycles=%0d sat0=%0d sat2=%0d, required 4 3 0", cyc, d0_sat_cnt, d2_sat_cnt);
    end
  endtask

  task automatic test_shift();
    int cyc;
    clear_sat();
    send(pk(256, -256, 7, -7));
    wait_idle(cyc);
    tests++;
    if (cyc !== 4 || d2_sat_cnt !== 16'd0 || d0_sat_cnt !== 16'd2) begin
      fails++;
      $display("FAIL shift: got cycles=%0d sat2=%0d sat0=%0d, required 4 0 2", cyc, d2_sat_cnt, d0_sat_cnt);
    end
  endtask

  task automatic test_sat_clear();
    int cyc;
    sat_clear = 1'b1;
    send(pk(300, -300, 1, 2));
    wait_idle(cyc);
    tests++;
    if (d0_sat_cnt !== 16'd0) begin
      fails++;
      $display("FAIL sat_clear_wins: got sat=%0d, required 0", d0_sat_cnt);
    end
    @(posedge clk); #1 sat_clear = 1'b0;
  endtask

  task automatic test_stall();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       prev_stall = 1'b0;
    logic [7:0] pd;
    logic [1:0] pi;
    logic       pl;
    int hs = 0;
    clear_sat();
    send(pk(1, 2, 3, 4));
    for (int i = 0; i < 40; i++) begin
      out_ready = pat[i % 4];
      @(negedge clk);
      if (!d0_out_valid) break;
      if (prev_stall) begin
        tests++;
        if (d0_out_data !== pd || d0_out_idx !== pi || d0_out_last !== pl) begin
          fails++;
          $display("FAIL stall_hold: got data=%0d idx=%0d last=%0b, required %0d %0d %0b",
                   d0_out_data, d0_out_idx, d0_out_last, pd, pi, pl);
        end
      end
      if (out_ready) hs++;
      prev_stall = !out_ready;
      pd = d0_out_data; pi = d0_out_idx; pl = d0_out_last;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    tests++;
    if (hs !== 4) begin fails++; $display("FAIL stall_handshakes: got %0d, required 4", hs); end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int caps = 0;
    logic drop;
    out_ready = 1'b1;
    in_data = pk(1, -1, 2, -2);
    in_valid = 1'b1;
    @(posedge clk); #1 in_data = pk(50, 60, 70, 80);
    for (int n = 0; n < 100; n++) begin
      drop = 1'b0;
      @(negedge clk);
      if (!d0_out_valid) break;
      cyc++;
      if (in_valid && d0_in_ready) begin
        caps++;
        drop = 1'b1;
        tests++;
        if (d0_out_last !== 1'b1 || d0_out_idx !== 2'd3) begin
          fails++;
          $display("FAIL b2b_capture_point: got last=%0b idx=%0d, required 1 3", d0_out_last, d0_out_idx);
        end
      end
      @(posedge clk); #1;
      if (drop) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    tests++;
    if (cyc !== 8 || caps !== 1) begin
      fails++;
      $display("FAIL b2b_contiguous: got cycles=%0d captures=%0d, required 8 1", cyc, caps);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    clear_sat();
    out_ready = 1'b1;
    send(pk(300, 5, 6, 7));
    for (int n = 0; n < 20 && k < 2; n++) begin
      @(negedge clk);
      if (d0_out_valid && out_ready) k++;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    tests++;
    if (d0_out_valid !== 1'b0 || d2_out_valid !== 1'b0 || d0_sat_cnt !== 16'd0 || k !== 2) begin
      fails++;
      $display("FAIL reset_mid: got v0=%0b v2=%0b sat=%0d hs=%0d, required 0 0 0 2",
               d0_out_valid, d2_out_valid, d0_sat_cnt, k);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      tests++;
      if (d0_in_ready !== 1'b1 || d0_out_valid !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_release: got in_ready=%0b out_valid=%0b, required 1 0", d0_in_ready, d0_out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_shift();
    test_sat_clear();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    tests++;
    if (q0.size() != 0) begin fails++; $display("FAIL sb_leftover: got %0d pending, required 0", q0.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
